// File: rtl/hazard_pkg.sv
// Shared types and defaults for the hazard control unit.
// Included by the scoreboard and by the top-level FSM.
package hazard_pkg;

  localparam int DEPTH_DEF        = 4;
  localparam int FLUSH_CYCLES_DEF = 3;
  localparam int YOUNG_SLOTS_DEF  = 2;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
  } sb_entry_t;

endpackage

// File: rtl/writer_scoreboard.sv
// In-flight writer tracking: shift register of destination registers
// with young-slot invalidation and source-register match detection.
module writer_scoreboard
  import hazard_pkg::*;
#(
  parameter int DEPTH       = DEPTH_DEF,
  parameter int YOUNG_SLOTS = YOUNG_SLOTS_DEF
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       load_valid,
  input  logic [4:0] load_rd,
  input  logic       invalidate,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       rs1_used,
  input  logic       rs2_used,
  output logic       match,
  output logic [2:0] count
);

  sb_entry_t slots [DEPTH];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++)
        slots[i] <= '0;
    end else begin
      slots[0] <= '{valid: load_valid, rd: load_rd};
      for (int i = 1; i < DEPTH; i++)
        slots[i] <= slots[i-1];
      // a taken branch kills writers younger than it
      if (invalidate)
        for (int i = 0; i < YOUNG_SLOTS && i < DEPTH; i++)
          slots[i].valid <= 1'b0;
    end
  end

  logic hit1;
  logic hit2;

  always_comb begin
    hit1  = 1'b0;
    hit2  = 1'b0;
    count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slots[i].valid && slots[i].rd == rs1)
        hit1 = 1'b1;
      if (slots[i].valid && slots[i].rd == rs2)
        hit2 = 1'b1;
      count = count + 3'(slots[i].valid);
    end
  end

  assign match = (rs1_used && rs1 != 5'd0 && hit1)
              || (rs2_used && rs2 != 5'd0 && hit2);

endmodule

// File: rtl/hazard_control_unit.sv
// Load-use stall and branch flush control for the in-order pipeline.
// Holds the RUN/STALL/FLUSH FSM and flush counter around the scoreboard.
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int DEPTH        = DEPTH_DEF,
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
  parameter int YOUNG_SLOTS  = YOUNG_SLOTS_DEF
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_rs1_used,
  input  logic       id_rs2_used,
  input  logic [4:0] id_rd,
  input  logic       id_regwrite,
  input  logic       ex_branch_taken,
  output logic       stall_out,
  output logic       bubble_out,
  output logic       flush_out,
  output logic [2:0] pending_count,
  output logic [1:0] state_out
);

  localparam int CW = $clog2(FLUSH_CYCLES) + 1;

  state_e        state_q;
  state_e        state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  logic sb_match;
  logic hazard;
  logic in_flush;
  logic branch;
  logic load_valid;

  assign in_flush   = (state_q == FLUSH);
  assign branch     = ex_branch_taken && !in_flush;
  assign hazard     = id_valid && sb_match;
  assign flush_out  = in_flush || branch;
  assign stall_out  = hazard && !flush_out;
  assign bubble_out = stall_out;
  assign state_out  = state_q;

  assign load_valid = id_valid && id_regwrite && (id_rd != 5'd0)
                   && !stall_out && !flush_out;

  writer_scoreboard #(
    .DEPTH       (DEPTH),
    .YOUNG_SLOTS (YOUNG_SLOTS)
  ) u_sb (
    .CLK        (CLK),
    .RESET      (RESET),
    .load_valid (load_valid),
    .load_rd    (id_rd),
    .invalidate (branch),
    .rs1        (id_rs1),
    .rs2        (id_rs2),
    .rs1_used   (id_rs1_used),
    .rs2_used   (id_rs2_used),
    .match      (sb_match),
    .count      (pending_count)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN, STALL: begin
        if (branch) begin
          // branch cycle itself is the first flush cycle
          state_d = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
          cnt_d   = CW'(FLUSH_CYCLES - 1);
        end else begin
          state_d = hazard ? STALL : RUN;
        end
      end
      FLUSH: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q <= CW'(1))
          state_d = RUN;
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit.
// Directed scenarios plus random traffic against a list-based model.
module tb_hazard_control_unit;

  localparam int DEPTH = 4;
  localparam int FC    = 3;
  localparam int YS    = 2;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_rs1_used;
  logic       id_rs2_used;
  logic [4:0] id_rd;
  logic       id_regwrite;
  logic       ex_branch_taken;
  logic       stall_out;
  logic       bubble_out;
  logic       flush_out;
  logic [2:0] pending_count;
  logic [1:0] state_out;

  hazard_control_unit #(
    .DEPTH        (DEPTH),
    .FLUSH_CYCLES (FC),
    .YOUNG_SLOTS  (YS)
  ) dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .id_valid        (id_valid),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_rs1_used     (id_rs1_used),
    .id_rs2_used     (id_rs2_used),
    .id_rd           (id_rd),
    .id_regwrite     (id_regwrite),
    .ex_branch_taken (ex_branch_taken),
    .stall_out       (stall_out),
    .bubble_out      (bubble_out),
    .flush_out       (flush_out),
    .pending_count   (pending_count),
    .state_out       (state_out)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // model: list of in-flight destination registers, 0 = empty
  int m_rd [DEPTH];
  int m_flush_left;
  bit m_stalled;

  bit e_br, e_flush, e_hazard, e_stall;
  int e_pend, e_state;

  function automatic bit in_flight(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    foreach (m_rd[i])
      if (m_rd[i] == int'(r)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_eval();
    e_br     = ex_branch_taken && (m_flush_left == 0);
    e_flush  = (m_flush_left > 0) || e_br;
    e_hazard = id_valid && ((id_rs1_used && in_flight(id_rs1))
                         || (id_rs2_used && in_flight(id_rs2)));
    e_stall  = e_hazard && !e_flush;
    e_pend   = 0;
    foreach (m_rd[i])
      if (m_rd[i] != 0) e_pend++;
    e_state  = (m_flush_left > 0) ? 2 : (m_stalled ? 1 : 0);
  endfunction

  function automatic void model_commit();
    if (RESET) begin
      foreach (m_rd[i]) m_rd[i] = 0;
      m_flush_left = 0;
      m_stalled    = 1'b0;
    end else begin
      for (int i = DEPTH - 1; i > 0; i--) m_rd[i] = m_rd[i-1];
      m_rd[0] = (id_valid && id_regwrite && !e_stall && !e_flush)
              ? int'(id_rd) : 0;
      if (e_br)
        for (int i = 0; i < YS; i++) m_rd[i] = 0;
      m_stalled = e_hazard && !e_flush;
      if (e_br) m_flush_left = FC - 1;
      else if (m_flush_left > 0) m_flush_left--;
    end
  endfunction

  task automatic tick();
    model_eval();
    @(posedge CLK);
    model_commit();
    #1;
  endtask

  task automatic settle();
    @(negedge CLK);
    model_eval();
  endtask

  task automatic idle();
    id_valid        = 1'b0;
    id_rs1          = '0;
    id_rs2          = '0;
    id_rs1_used     = 1'b0;
    id_rs2_used     = 1'b0;
    id_rd           = '0;
    id_regwrite     = 1'b0;
    ex_branch_taken = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
  endtask

  task automatic writer(input logic [4:0] rd);
    idle();
    id_valid    = 1'b1;
    id_rd       = rd;
    id_regwrite = 1'b1;
  endtask

  task automatic reader(input logic [4:0] r1, input logic [4:0] r2,
                        input logic u2);
    idle();
    id_valid    = 1'b1;
    id_rs1      = r1;
    id_rs1_used = 1'b1;
    id_rs2      = r2;
    id_rs2_used = u2;
  endtask

  task automatic test_reset();
    writer(5'd5);
    ex_branch_taken = 1'b1;
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    idle();
    settle();
    n_tests++;
    if (stall_out !== 1'b0) begin
      n_fail++; $display("FAIL reset_stall: got %b expected 0", stall_out);
    end
    n_tests++;
    if (bubble_out !== 1'b0) begin
      n_fail++; $display("FAIL reset_bubble: got %b expected 0", bubble_out);
    end
    n_tests++;
    if (flush_out !== 1'b0) begin
      n_fail++; $display("FAIL reset_flush: got %b expected 0", flush_out);
    end
    n_tests++;
    if (pending_count !== 3'd0) begin
      n_fail++; $display("FAIL reset_pending: got %0d expected 0", pending_count);
    end
    n_tests++;
    if (state_out !== 2'd0) begin
      n_fail++; $display("FAIL reset_state: got %0d expected 0", state_out);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int stalls;
    int peak;
    bit released;
    stalls = 0; peak = 0; released = 1'b0;
    do_reset();
    writer(5'd5);
    settle();
    n_tests++;
    if (stall_out !== 1'b0) begin
      n_fail++; $display("FAIL b2b_producer_stall: got %b expected 0", stall_out);
    end
    tick();
    reader(5'd5, 5'd0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      settle();
      n_tests++;
      if (stall_out !== e_stall || bubble_out !== e_stall) begin
        n_fail++;
        $display("FAIL b2b_stall_cycle%0d: got %b/%b expected %b",
                 k, stall_out, bubble_out, e_stall);
      end
      if (int'(pending_count) > peak) peak = int'(pending_count);
      if (!stall_out) begin
        released = 1'b1;
        tick();
        break;
      end
      stalls++;
      tick();
    end
    idle();
    n_tests++;
    if (!released || stalls != 4) begin
      n_fail++; $display("FAIL b2b_stall_len: got %0d expected 4", stalls);
    end
    n_tests++;
    if (peak != 1) begin
      n_fail++; $display("FAIL b2b_peak_pending: got %0d expected 1", peak);
    end
  endtask

  task automatic test_x0();
    do_reset();
    writer(5'd0);
    tick();
    reader(5'd0, 5'd0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      settle();
      n_tests++;
      if (stall_out !== 1'b0 || pending_count !== 3'd0) begin
        n_fail++;
        $display("FAIL x0_cycle%0d: got stall=%b pend=%0d expected 0/0",
                 k, stall_out, pending_count);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_branch_in_stall();
    int flushes;
    do_reset();
    writer(5'd7);
    tick();
    reader(5'd7, 5'd0, 1'b0);
    tick();
    settle();
    n_tests++;
    if (stall_out !== 1'b1 || state_out !== 2'd1) begin
      n_fail++;
      $display("FAIL br_pre_stall: got stall=%b state=%0d expected 1/1",
               stall_out, state_out);
    end
    ex_branch_taken = 1'b1;
    #1;
    model_eval();
    n_tests++;
    if (stall_out !== 1'b0 || bubble_out !== 1'b0 || flush_out !== 1'b1) begin
      n_fail++;
      $display("FAIL br_same_cycle: got stall=%b bubble=%b flush=%b expected 0/0/1",
               stall_out, bubble_out, flush_out);
    end
    flushes = 1;
    tick();
    idle();
    settle();
    n_tests++;
    if (state_out !== 2'd2 || pending_count !== 3'd1) begin
      n_fail++;
      $display("FAIL br_first_flush: got state=%0d pend=%0d expected 2/1",
               state_out, pending_count);
    end
    for (int k = 0; k < 6; k++) begin
      n_tests++;
      if (state_out !== 2'(e_state) || flush_out !== e_flush) begin
        n_fail++;
        $display("FAIL br_flush_seq%0d: got state=%0d flush=%b expected %0d/%b",
                 k, state_out, flush_out, e_state, e_flush);
      end
      if (!flush_out) break;
      flushes++;
      tick();
      settle();
    end
    n_tests++;
    if (flushes != 3 || state_out !== 2'd0) begin
      n_fail++;
      $display("FAIL br_flush_len: got %0d state=%0d expected 3/0",
               flushes, state_out);
    end
    tick();
  endtask

  task automatic test_mid_flush_reset();
    do_reset();
    writer(5'd3);
    tick();
    writer(5'd9);
    tick();
    idle();
    ex_branch_taken = 1'b1;
    settle();
    n_tests++;
    if (flush_out !== 1'b1) begin
      n_fail++; $display("FAIL mfr_flush1: got %b expected 1", flush_out);
    end
    tick();
    ex_branch_taken = 1'b0;
    settle();
    n_tests++;
    if (state_out !== 2'd2 || pending_count !== 2'(e_pend)) begin
      n_fail++;
      $display("FAIL mfr_flush2: got state=%0d pend=%0d expected 2/%0d",
               state_out, pending_count, e_pend);
    end
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    settle();
    n_tests++;
    if (flush_out !== 1'b0 || state_out !== 2'd0 || pending_count !== 3'd0) begin
      n_fail++;
      $display("FAIL mfr_after: got flush=%b state=%0d pend=%0d expected 0/0/0",
               flush_out, state_out, pending_count);
    end
    tick();
    writer(5'd4);
    tick();
    reader(5'd4, 5'd0, 1'b0);
    tick();
    settle();
    n_tests++;
    if (state_out !== 2'd1) begin
      n_fail++; $display("FAIL rst_vs_br_pre: got %0d expected 1", state_out);
    end
    RESET = 1'b1;
    ex_branch_taken = 1'b1;
    tick();
    RESET = 1'b0;
    idle();
    settle();
    n_tests++;
    if (flush_out !== 1'b0 || state_out !== 2'd0 || pending_count !== 3'd0) begin
      n_fail++;
      $display("FAIL rst_vs_br: got flush=%b state=%0d pend=%0d expected 0/0/0",
               flush_out, state_out, pending_count);
    end
    tick();
  endtask

  task automatic test_full();
    int stalls;
    bit released;
    stalls = 0; released = 1'b0;
    do_reset();
    for (int r = 1; r <= 4; r++) begin
      writer(5'(r));
      tick();
    end
    reader(5'd1, 5'd4, 1'b0);
    settle();
    n_tests++;
    if (pending_count !== 3'd4) begin
      n_fail++; $display("FAIL full_pending: got %0d expected 4", pending_count);
    end
    for (int k = 0; k < 10; k++) begin
      if (k > 0) settle();
      if (!stall_out) begin
        released = 1'b1;
        tick();
        break;
      end
      stalls++;
      tick();
    end
    idle();
    n_tests++;
    if (!released || stalls != 1) begin
      n_fail++; $display("FAIL full_stall_len: got %0d expected 1", stalls);
    end
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      RESET           = ($urandom_range(0, 63) == 0);
      id_valid        = ($urandom_range(0, 3) != 0);
      id_rs1          = 5'($urandom_range(0, 7));
      id_rs2          = 5'($urandom_range(0, 7));
      id_rs1_used     = $urandom_range(0, 1) != 0;
      id_rs2_used     = $urandom_range(0, 1) != 0;
      id_rd           = 5'($urandom_range(0, 7));
      id_regwrite     = $urandom_range(0, 1) != 0;
      ex_branch_taken = ($urandom_range(0, 9) == 0);
      settle();
      n_tests++;
      if (stall_out !== e_stall || bubble_out !== e_stall
          || flush_out !== e_flush || pending_count !== 3'(e_pend)
          || state_out !== 2'(e_state)) begin
        n_fail++;
        errs++;
        if (errs <= 10)
          $display("FAIL rand_cycle%0d: got s=%b b=%b f=%b p=%0d st=%0d expected s=%b f=%b p=%0d st=%0d",
                   k, stall_out, bubble_out, flush_out, pending_count,
                   state_out, e_stall, e_flush, e_pend, e_state);
      end
      tick();
    end
    RESET = 1'b0;
    idle();
  endtask

  initial begin
    RESET = 1'b1;
    idle();
    foreach (m_rd[i]) m_rd[i] = 0;
    m_flush_left = 0;
    m_stalled    = 1'b0;
    #1;
    tick();
    test_reset();
    test_back_to_back();
    test_x0();
    test_branch_in_stall();
    test_mid_flush_reset();
    test_full();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
